// File: rtl/ballot_collector_n1_m4_if.sv
// Ballot intake and verdict handoff handshakes for the ballot collector.
interface ballot_collector_n1_m4_if #(
  parameter int ID_W = 4
);
  logic            vote_valid;
  logic            vote_ready;
  logic [ID_W-1:0] vote_id;
  logic            vote_bit;
  logic            result_valid;
  logic            result_ready;
  logic            result;

  modport master (
    output vote_valid, vote_id, vote_bit, result_ready,
    input  vote_ready, result_valid, result
  );

  modport slave (
    input  vote_valid, vote_id, vote_bit, result_ready,
    output vote_ready, result_valid, result
  );
endinterface

// File: rtl/ballot_collector_n1_m4.sv
// Collects one ballot per voter, freezes the vector for the voter's settle time,
// then hands the sampled verdict downstream over valid/ready.
module ballot_collector_n1_m4 #(
  parameter int NUM_VOTERS = 16,
  parameter int ID_W       = 4,
  parameter int EVAL_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ballot_collector_n1_m4_if.slave bus,
  input  logic                  close_poll,
  output logic                  dup_err,
  output logic [ID_W:0]         vote_count,
  output logic [NUM_VOTERS-1:0] p_vec,
  input  logic                  voter_o
);

  localparam int CNT_W = (EVAL_LAT > 1) ? $clog2(EVAL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EVAL_LAT - 1);
  localparam logic [ID_W:0]    CNT_FULL = (ID_W + 1)'(NUM_VOTERS);
  localparam logic [ID_W:0]    CNT_PRE  = (ID_W + 1)'(NUM_VOTERS - 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_EVAL    = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_VOTERS-1:0] ballot_q, ballot_d;
  logic [NUM_VOTERS-1:0] cast_q, cast_d;
  logic [ID_W:0]         count_q, count_d;
  logic [CNT_W-1:0]      eval_cnt_q, eval_cnt_d;
  logic                  result_q, result_d;
  logic                  result_vld_q, result_vld_d;
  logic                  dup_q, dup_d;
  logic                  accept;
  logic                  id_ok;

  assign accept = bus.vote_valid && (state_q == S_COLLECT);
  assign id_ok  = (32'(bus.vote_id) < NUM_VOTERS);

  always_comb begin
    state_d      = state_q;
    ballot_d     = ballot_q;
    cast_d       = cast_q;
    count_d      = count_q;
    eval_cnt_d   = eval_cnt_q;
    result_d     = result_q;
    result_vld_d = result_vld_q;
    dup_d        = 1'b0;

    case (state_q)
      S_COLLECT: begin
        eval_cnt_d = '0;
        if (accept) begin
          if (id_ok && !cast_q[bus.vote_id]) begin
            ballot_d[bus.vote_id] = bus.vote_bit;
            cast_d[bus.vote_id]   = 1'b1;
            if (count_q != CNT_FULL) begin
              count_d = count_q + 1'b1;
            end
            if (count_q == CNT_PRE) begin
              state_d = S_EVAL;
            end
          end else begin
            dup_d = 1'b1;
          end
        end
        // A ballot offered alongside close_poll is still taken above.
        if (close_poll) begin
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (eval_cnt_q == CNT_LAST) begin
          result_d     = voter_o;
          result_vld_d = 1'b1;
          eval_cnt_d   = '0;
          state_d      = S_DONE;
        end else begin
          eval_cnt_d = eval_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (bus.result_ready) begin
          ballot_d     = '0;
          cast_d       = '0;
          count_d      = '0;
          result_vld_d = 1'b0;
          state_d      = S_COLLECT;
        end
      end
      default: begin
        ballot_d     = '0;
        cast_d       = '0;
        count_d      = '0;
        eval_cnt_d   = '0;
        result_d     = 1'b0;
        result_vld_d = 1'b0;
        state_d      = S_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_COLLECT;
      ballot_q     <= '0;
      cast_q       <= '0;
      count_q      <= '0;
      eval_cnt_q   <= '0;
      result_q     <= 1'b0;
      result_vld_q <= 1'b0;
      dup_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ballot_q     <= ballot_d;
      cast_q       <= cast_d;
      count_q      <= count_d;
      eval_cnt_q   <= eval_cnt_d;
      result_q     <= result_d;
      result_vld_q <= result_vld_d;
      dup_q        <= dup_d;
    end
  end

  assign bus.vote_ready   = (state_q == S_COLLECT);
  assign bus.result_valid = result_vld_q;
  assign bus.result       = result_q;
  assign dup_err          = dup_q;
  assign vote_count       = count_q;
  assign p_vec            = ballot_q;

endmodule

// File: tb/tb_ballot_collector_n1_m4.sv
// Directed bench for the ballot collector with a 9-of-16 majority voter model.
module tb_ballot_collector_n1_m4;
  logic        clk;
  logic        rst_n;
  logic        close_poll;
  logic        dup_err;
  logic [4:0]  vote_count;
  logic [15:0] p_vec;
  logic        voter_o;
  int          total;
  int          bad;

  ballot_collector_n1_m4_if #(.ID_W(4)) bus ();

  ballot_collector_n1_m4 #(
    .NUM_VOTERS(16),
    .ID_W      (4),
    .EVAL_LAT  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .close_poll(close_poll),
    .dup_err   (dup_err),
    .vote_count(vote_count),
    .p_vec     (p_vec),
    .voter_o   (voter_o)
  );

  assign voter_o = ($countones(p_vec) > 8);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic vote(input logic [3:0] id, input logic b);
    bus.vote_valid = 1'b1;
    bus.vote_id    = id;
    bus.vote_bit   = b;
    @(negedge clk);
    bus.vote_valid = 1'b0;
  endtask

  task automatic close_it();
    close_poll = 1'b1;
    @(negedge clk);
    close_poll = 1'b0;
  endtask

  task automatic wait_rv(input string tag);
    for (int i = 0; i < 20 && !bus.result_valid; i++) @(negedge clk);
    chk(tag, {31'd0, bus.result_valid}, 32'd1);
  endtask

  task automatic take_result();
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total            = 0;
    bad              = 0;
    rst_n            = 1'b0;
    close_poll       = 1'b0;
    bus.vote_valid   = 1'b0;
    bus.vote_id      = '0;
    bus.vote_bit     = 1'b0;
    bus.result_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, bus.vote_ready}, 32'd1);
    chk("rst_pvec", {16'd0, p_vec}, 32'd0);
    chk("rst_count", {27'd0, vote_count}, 32'd0);
    chk("rst_rv", {31'd0, bus.result_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: full house, alternating 1/0, automatic close
    for (int i = 0; i < 16; i++) vote(4'(i), (i % 2) == 0);
    chk("t1_pvec", {16'd0, p_vec}, 32'h5555);
    chk("t1_count", {27'd0, vote_count}, 32'd16);
    chk("t1_ready_eval", {31'd0, bus.vote_ready}, 32'd0);
    @(negedge clk);
    chk("t1_rv_early", {31'd0, bus.result_valid}, 32'd0);
    chk("t1_pvec_frozen", {16'd0, p_vec}, 32'h5555);
    @(negedge clk);
    chk("t1_rv_on_time", {31'd0, bus.result_valid}, 32'd1);
    chk("t1_result", {31'd0, bus.result}, 32'd0);
    take_result();
    chk("t1_ready_back", {31'd0, bus.vote_ready}, 32'd1);
    chk("t1_count_clr", {27'd0, vote_count}, 32'd0);
    chk("t1_pvec_clr", {16'd0, p_vec}, 32'd0);
    chk("t1_rv_clr", {31'd0, bus.result_valid}, 32'd0);

    // T2: duplicate ballot from voter 5
    vote(4'd5, 1'b1);
    chk("t2_dup_first", {31'd0, dup_err}, 32'd0);
    vote(4'd5, 1'b0);
    chk("t2_dup_pulse", {31'd0, dup_err}, 32'd1);
    chk("t2_pvec", {16'd0, p_vec}, 32'h0020);
    chk("t2_count", {27'd0, vote_count}, 32'd1);
    @(negedge clk);
    chk("t2_dup_gone", {31'd0, dup_err}, 32'd0);
    close_it();
    wait_rv("t2_rv");
    chk("t2_result", {31'd0, bus.result}, 32'd0);
    take_result();

    // T3: 9 yes then early close
    for (int i = 0; i < 9; i++) vote(4'(i), 1'b1);
    chk("t3_count", {27'd0, vote_count}, 32'd9);
    close_it();
    chk("t3_pvec", {16'd0, p_vec}, 32'h01FF);
    wait_rv("t3_rv");
    chk("t3_result", {31'd0, bus.result}, 32'd1);
    take_result();

    // T4: empty poll, downstream stalls
    close_it();
    chk("t4_pvec", {16'd0, p_vec}, 32'd0);
    wait_rv("t4_rv");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_rv_hold", {31'd0, bus.result_valid}, 32'd1);
      chk("t4_res_hold", {31'd0, bus.result}, 32'd0);
    end
    take_result();
    chk("t4_pvec_clr", {16'd0, p_vec}, 32'd0);
    chk("t4_count_clr", {27'd0, vote_count}, 32'd0);
    chk("t4_ready", {31'd0, bus.vote_ready}, 32'd1);

    // T5: ballot and close in the same cycle
    close_poll     = 1'b1;
    bus.vote_valid = 1'b1;
    bus.vote_id    = 4'd3;
    bus.vote_bit   = 1'b1;
    @(negedge clk);
    close_poll     = 1'b0;
    bus.vote_valid = 1'b0;
    chk("t5_pvec", {16'd0, p_vec}, 32'h0008);
    chk("t5_count", {27'd0, vote_count}, 32'd1);
    chk("t5_ready", {31'd0, bus.vote_ready}, 32'd0);
    close_it();
    chk("t5_pvec_frozen", {16'd0, p_vec}, 32'h0008);
    wait_rv("t5_rv");
    chk("t5_result", {31'd0, bus.result}, 32'd0);
    take_result();

    // T6: reset during EVAL, then a clean poll
    for (int i = 0; i < 12; i++) vote(4'(i), 1'b1);
    close_it();
    chk("t6_in_eval", {31'd0, bus.vote_ready}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_ready", {31'd0, bus.vote_ready}, 32'd1);
    chk("t6_pvec", {16'd0, p_vec}, 32'd0);
    chk("t6_count", {27'd0, vote_count}, 32'd0);
    chk("t6_rv", {31'd0, bus.result_valid}, 32'd0);
    chk("t6_result", {31'd0, bus.result}, 32'd0);
    chk("t6_dup", {31'd0, dup_err}, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 16; i++) vote(4'(i), 1'b1);
    chk("t6_pvec_full", {16'd0, p_vec}, 32'hFFFF);
    wait_rv("t6_rv_new");
    chk("t6_result_new", {31'd0, bus.result}, 32'd1);
    take_result();
    chk("t6_ready_end", {31'd0, bus.vote_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
